stack_lifo: RTL and testbench

//  Parameterised synchronous LIFO (stack) buffer holding up to LENGTH words of WIDTH bits.

---
 rtl/stack_lifo_if.sv | 32 +++
 rtl/stack_lifo.sv | 91 +++++++++
 tb/tb_stack_lifo.sv | 131 +++++++++++++
 3 files changed

// File: rtl/stack_lifo_if.sv
// Handshake/data bundle for stack_lifo. The overflow_o and underflow_o flags
// exist only when STACK_ERR_FLAGS_EN is defined.
interface stack_lifo_if #(
  parameter int WIDTH = 8
);
  logic             push_i;
  logic             pop_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             full;
  logic             empty;
`ifdef STACK_ERR_FLAGS_EN
  logic             overflow_o;
  logic             underflow_o;
`endif

  modport master (
    output push_i, pop_i, data_i,
`ifdef STACK_ERR_FLAGS_EN
    input  overflow_o, underflow_o,
`endif
    input  data_o, full, empty
  );

  modport slave (
    input  push_i, pop_i, data_i,
`ifdef STACK_ERR_FLAGS_EN
    output overflow_o, underflow_o,
`endif
    output data_o, full, empty
  );
endinterface

// File: rtl/stack_lifo.sv
// Synchronous LIFO of LENGTH words of WIDTH bits with a registered pop output.
// Optional STACK_ERR_FLAGS_EN adds registered overflow/underflow pulse outputs.
module stack_lifo #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 5
) (
  input  logic          clk,
  input  logic          rstn,
  stack_lifo_if.slave   bus
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam int AW = $clog2(LENGTH);

  logic [WIDTH-1:0] mem_q [LENGTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_w, empty_w;
  logic             we;
  logic [AW-1:0]    waddr, top_idx;

  assign full_w  = (cnt_q == CW'(LENGTH));
  assign empty_w = (cnt_q == '0);
  assign top_idx = AW'(cnt_q - CW'(1));

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    we     = 1'b0;
    waddr  = AW'(cnt_q);
    unique case ({bus.push_i, bus.pop_i})
      2'b10: begin
        if (!full_w) begin
          we    = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      2'b01: begin
        if (!empty_w) begin
          data_d = mem_q[top_idx];
          cnt_d  = cnt_q - CW'(1);
        end
      end
      2'b11: begin
        // Simultaneous push/pop swaps the top word; on an empty stack it is a pass-through.
        if (empty_w) begin
          data_d = bus.data_i;
        end else begin
          data_d = mem_q[top_idx];
          we     = 1'b1;
          waddr  = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rstn) mem_q[waddr] <= bus.data_i;
  end

  assign bus.data_o = data_q;
  assign bus.full   = full_w;
  assign bus.empty  = empty_w;

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= bus.push_i && !bus.pop_i && full_w;
      unf_q <= bus.pop_i && !bus.push_i && empty_w;
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
`endif
endmodule

// File: tb/tb_stack_lifo.sv
// Scoreboard bench for stack_lifo (WIDTH=8, LENGTH=5): stimulus queues hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_stack_lifo;
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  stack_lifo_if #(.WIDTH(8)) bus ();

  stack_lifo #(.WIDTH(8), .LENGTH(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       full;
    logic       empty;
    logic       ov;
    logic       un;
    string      nm;
  } exp_t;

  exp_t sb_q [$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s stale: sampled at cycle %0d expected cycle %0d", e.nm, cyc, e.cyc);
      end else begin
        chk({e.nm, ".data_o"}, bus.data_o, e.d);
        chk({e.nm, ".full"}, {7'b0, bus.full}, {7'b0, e.full});
        chk({e.nm, ".empty"}, {7'b0, bus.empty}, {7'b0, e.empty});
`ifdef STACK_ERR_FLAGS_EN
        chk({e.nm, ".overflow_o"}, {7'b0, bus.overflow_o}, {7'b0, e.ov});
        chk({e.nm, ".underflow_o"}, {7'b0, bus.underflow_o}, {7'b0, e.un});
`endif
      end
    end
  end

  task automatic step(input logic r, input logic p, input logic o, input logic [7:0] din,
                      input logic [7:0] ed, input logic ef, input logic ee,
                      input logic eov, input logic eun, input string nm);
    exp_t e;
    rstn       = r;
    bus.push_i = p;
    bus.pop_i  = o;
    bus.data_i = din;
    e.cyc   = cyc + 1;
    e.d     = ed;
    e.full  = ef;
    e.empty = ee;
    e.ov    = eov;
    e.un    = eun;
    e.nm    = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] a;
    a = 8'h61;
    rstn = 1'b1;
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    bus.data_i = 8'h00;

    // 1 reset
    for (int i = 0; i < 2; i++) step(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, "reset");

    // 2 push a..p, only a..e stored
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, a + 8'(i), 8'h00, i >= 4, 0, i >= 5, 0, $sformatf("push%0d", i));

    // 3 pop 20: e,d,c,b,a then hold a
    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 8'h00, (i < 5) ? 8'h65 - 8'(i) : 8'h61, 0, i >= 4, 0, i >= 5,
           $sformatf("pop%0d", i));

    // 4 push&pop on empty stack bypasses
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, a + 8'(i), a + 8'(i), 0, 1, 0, 0, $sformatf("bypass%0d", i));

    // 5 fill, then swap top with 'x'
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, a + 8'(i), 8'h64, i == 4, 0, 0, 0, $sformatf("fill%0d", i));
    step(0, 1, 1, 8'h78, 8'h65, 1, 0, 0, 0, "swap_full");
    step(0, 0, 1, 8'h00, 8'h78, 0, 0, 0, 0, "pop_swapped");
    step(0, 0, 1, 8'h00, 8'h64, 0, 0, 0, 0, "pop_after_swap");

    // 6 reset mid-sequence discards contents
    step(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, "reset2");
    step(0, 1, 0, 8'h70, 8'h00, 0, 0, 0, 0, "push_p");
    step(0, 1, 0, 8'h71, 8'h00, 0, 0, 0, 0, "push_q");
    step(1, 1, 0, 8'h72, 8'h00, 0, 1, 0, 0, "reset_mid_push");
    step(0, 0, 1, 8'h00, 8'h00, 0, 1, 0, 1, "pop_after_reset");
    step(0, 1, 0, 8'h73, 8'h00, 0, 0, 0, 0, "push_s");
    step(0, 0, 1, 8'h00, 8'h73, 0, 1, 0, 0, "pop_s");
    step(0, 0, 0, 8'h00, 8'h73, 0, 1, 0, 0, "idle_hold");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
